// File: rtl/framer_pkg.sv
// Shared tag codes, FSM state type and footer field layout for trigger_window_framer.
package framer_pkg;

  localparam logic [1:0] TAG_HDR  = 2'b01;
  localparam logic [1:0] TAG_DATA = 2'b00;
  localparam logic [1:0] TAG_FTR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FOOTER  = 2'd2
  } state_t;

  // Footer payload layout, counted from bit 0 of the payload.
  localparam int FTR_CNT_LSB  = 0;
  localparam int FTR_DROP_LSB = 16;
  localparam int FTR_OVF_BIT  = 32;
  localparam int FTR_FIELD_W  = 16;
  localparam int FTR_CORE_W   = FTR_OVF_BIT + 1;

  function automatic logic [FTR_CORE_W-1:0] footer_core(
    input logic                   ovf,
    input logic [FTR_FIELD_W-1:0] drop,
    input logic [FTR_FIELD_W-1:0] cnt
  );
    logic [FTR_CORE_W-1:0] w;
    w = '0;
    w[FTR_OVF_BIT]                  = ovf;
    w[FTR_DROP_LSB +: FTR_FIELD_W]  = drop;
    w[FTR_CNT_LSB  +: FTR_FIELD_W]  = cnt;
    return w;
  endfunction

endpackage

// File: rtl/framer_sync_fifo.sv
// First-word-fall-through FIFO with a registered head word and a free-slot count.
// A word written at edge t becomes visible on dout after edge t+1.
module framer_sync_fifo #(
  parameter int  W     = 50,
  parameter int  DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic [AW:0]  free
);

  localparam logic [AW:0] CAP = DEPTH[AW:0];

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic [AW:0]  rd_ptr_next;
  logic [AW:0]  used;
  logic [W-1:0] dout_reg;
  logic         dout_valid_reg;
  logic         do_push;
  logic         do_pop;

  assign used        = wr_ptr_reg - rd_ptr_reg;
  assign free        = CAP - used;
  assign do_push     = push && (used != CAP);
  assign do_pop      = pop && dout_valid_reg;
  assign rd_ptr_next = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // The head fetch compares against the write pointer before this edge's push,
  // so a slot being written never collides with the slot being read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg     <= rd_ptr_next;
      dout_valid_reg <= (wr_ptr_reg != rd_ptr_next);
      if (wr_ptr_reg != rd_ptr_next) begin
        dout_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;

endmodule

// File: rtl/trigger_window_framer.sv
// Frames a delayed sample stream around undelayed triggers: header, window samples, status footer.
// Build option FRAMER_DROP_CNT_EN adds a self-clearing dropped-trigger count to the footer.
module trigger_window_framer
  import framer_pkg::*;
#(
  parameter int WIDTH     = 48,
  parameter int DEPTH     = 64,
  parameter int WIN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic [WIDTH-1:0]     time_stamp,
  input  logic                 trigger,
  input  logic [WIN_WIDTH-1:0] window_len,
  output logic [WIDTH+1:0]     dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy
);

  localparam int            FW       = $clog2(DEPTH) + 1;
  localparam logic [FW-1:0] MIN_FREE = FW'(2);
  localparam int            PAD_W    = WIDTH - FTR_CORE_W;

  state_t                 state_reg;
  state_t                 state_next;
  logic [WIN_WIDTH-1:0]   len_reg;
  logic [WIN_WIDTH-1:0]   seen_reg;
  logic [WIN_WIDTH-1:0]   cnt_reg;
  logic                   ovf_reg;
  logic [FW-1:0]          free;
  logic                   room;
  logic                   accept;
  logic                   sample_take;
  logic                   last_sample;
  logic                   push;
  logic [WIDTH+1:0]       push_data;
  logic [FTR_FIELD_W-1:0] drop_field;

  // Two free slots: one for the word written now, one held back for the footer.
  assign room        = (free >= MIN_FREE);
  assign accept      = (state_reg == IDLE) && trigger && room;
  assign sample_take = (state_reg == CAPTURE) && din_valid;
  assign last_sample = sample_take && ((seen_reg + 1'b1) == len_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (window_len == '0) ? FOOTER : CAPTURE;
        end
      end
      CAPTURE: begin
        if (last_sample) begin
          state_next = FOOTER;
        end
      end
      FOOTER:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    busy      = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (accept) begin
          push      = 1'b1;
          push_data = {TAG_HDR, time_stamp};
        end
      end
      CAPTURE: begin
        if (sample_take && room) begin
          push      = 1'b1;
          push_data = {TAG_DATA, din};
        end
      end
      FOOTER: begin
        push      = 1'b1;
        push_data = {TAG_FTR, {PAD_W{1'b0}},
                     footer_core(ovf_reg, drop_field, FTR_FIELD_W'(cnt_reg))};
      end
      default: begin
        push = 1'b0;
      end
    endcase
  end

  // seen_reg counts every consumed sample; cnt_reg only the ones that were stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg  <= '0;
      seen_reg <= '0;
      cnt_reg  <= '0;
      ovf_reg  <= 1'b0;
    end else if (accept) begin
      len_reg  <= window_len;
      seen_reg <= '0;
      cnt_reg  <= '0;
      ovf_reg  <= 1'b0;
    end else if (sample_take) begin
      seen_reg <= seen_reg + 1'b1;
      if (room) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else begin
        ovf_reg <= 1'b1;
      end
    end
  end

`ifdef FRAMER_DROP_CNT_EN
  logic [FTR_FIELD_W-1:0] drop_cnt_reg;
  logic                   drop_inc;

  assign drop_inc = trigger && !accept;

  // The footer cycle reports the old count; a trigger in that same cycle starts the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (state_reg == FOOTER) begin
      drop_cnt_reg <= {{(FTR_FIELD_W-1){1'b0}}, drop_inc};
    end else if (drop_inc && (drop_cnt_reg != '1)) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign drop_field = drop_cnt_reg;
`else
  assign drop_field = '0;
`endif

  framer_sync_fifo #(
    .W     (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .free       (free)
  );

endmodule

// File: tb/tb_trigger_window_framer.sv
// Directed bench for trigger_window_framer: table of frames plus hand-written overflow, zero-length and reset cases.
module tb_trigger_window_framer;

  localparam int WIDTH     = 48;
  localparam int DEPTH     = 16;
  localparam int WIN_WIDTH = 16;
  localparam int DW        = WIDTH + 2;
`ifdef FRAMER_DROP_CNT_EN
  localparam int D1 = 1;
`else
  localparam int D1 = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [WIDTH-1:0]     din = '0;
  logic                 din_valid = 1'b0;
  logic [WIDTH-1:0]     time_stamp = '0;
  logic                 trigger = 1'b0;
  logic [WIN_WIDTH-1:0] window_len = '0;
  logic [DW-1:0]        dout;
  logic                 dout_valid;
  logic                 dout_ready = 1'b1;
  logic                 busy;

  always #5 clk = ~clk;

  trigger_window_framer #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .WIN_WIDTH (WIN_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .time_stamp (time_stamp),
    .trigger    (trigger),
    .window_len (window_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  typedef struct {
    string name;
    int    start_ts;
    int    len;
    int    vmode;
    int    extra_k;
    int    rnd;
    int    exp_words;
    int    exp_cnt;
    int    exp_ovf;
    int    exp_drop;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  int            ts = 0;
  bit            rand_rdy = 1'b0;
  logic [DW-1:0] got[$];
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DW-1:0] prev_dout = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] din_val(input int t);
    return {16'hA5C3, 32'(t * 3 + 7)};
  endfunction

  function automatic logic [DW-1:0] ftr_word(input int cnt, input int ovf, input int drop);
    logic [DW-1:0] w;
    w = '0;
    w[49:48] = 2'b11;
    w[32]    = ovf[0];
    w[31:16] = drop[15:0];
    w[15:0]  = cnt[15:0];
    return w;
  endfunction

  function automatic bit vld(input int k, input int mode);
    if (mode == 1) return (k % 2) == 1;
    if (mode == 2) return (k % 2) == 0;
    return 1'b1;
  endfunction

  // Output monitor: records popped words and checks the hold-while-stalled rule.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 64'(dout_valid), 64'd1);
        check("hold_data", 64'(dout), 64'(prev_dout));
      end
      if (dout_valid && dout_ready) got.push_back(dout);
      prev_valid = dout_valid;
      prev_ready = dout_ready;
      prev_dout  = dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ts++;
    time_stamp = WIDTH'(ts);
    din        = din_val(ts);
    if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic compare_frame(input string name, input logic [DW-1:0] exp_q[$], input int exp_words);
    int n;
    check({name, "_words"}, 64'(got.size()), 64'(exp_words));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", name, i), 64'(got[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [DW-1:0] exp_q[$];
    int acc_ts;
    int k;
    int n;
    int taken;
    got.delete();
    if (v.start_ts > 0) begin
      n = 0;
      while (ts != v.start_ts && n < 1000) begin
        tick();
        n++;
      end
      check({v.name, "_start_ts"}, 64'(ts), 64'(v.start_ts));
    end
    rand_rdy = (v.rnd != 0);
    if (!rand_rdy) dout_ready = 1'b1;
    acc_ts = ts;
    exp_q.push_back({2'b01, WIDTH'(acc_ts)});
    k = 0;
    taken = 0;
    while (taken < v.len) begin
      k++;
      if (vld(k, v.vmode)) begin
        exp_q.push_back({2'b00, din_val(acc_ts + k)});
        taken++;
      end
    end
    exp_q.push_back(ftr_word(v.exp_cnt, v.exp_ovf, v.exp_drop));
    trigger    = 1'b1;
    window_len = WIN_WIDTH'(v.len);
    din_valid  = 1'b1;
    tick();
    k = 1;
    n = 0;
    while ((got.size() < v.exp_words || busy) && n < 300) begin
      din_valid = vld(k, v.vmode);
      trigger   = (k == v.extra_k);
      tick();
      k++;
      n++;
    end
    trigger   = 1'b0;
    din_valid = 1'b0;
    rand_rdy  = 1'b0;
    dout_ready = 1'b1;
    compare_frame(v.name, exp_q, v.exp_words);
    $display("frame %s: ts=%0d len=%0d words=%0d", v.name, acc_ts, v.len, got.size());
  endtask

  vec_t          vecs[6];
  vec_t          v5;
  logic [DW-1:0] eq[$];
  int            acc;
  int            n;

  initial begin
    vecs[0] = '{"t1_ts100",  100, 8, 0, -1, 0, 10, 8, 0, 0};
    vecs[1] = '{"t2_drop",     0, 8, 0,  3, 0, 10, 8, 0, D1};
    vecs[2] = '{"t2_cleared",  0, 5, 0, -1, 0,  7, 5, 0, 0};
    vecs[3] = '{"t6_odd_rnd",  0, 4, 1, -1, 1,  6, 4, 0, 0};
    vecs[4] = '{"t6_even_rnd", 0, 4, 2, -1, 1,  6, 4, 0, 0};
    vecs[5] = '{"len1",        0, 1, 0, -1, 0,  3, 1, 0, 0};

    tick();
    tick();
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Overflow: stalled output, window longer than the FIFO can hold.
    got.delete();
    dout_ready = 1'b0;
    trigger    = 1'b1;
    window_len = 16'd20;
    din_valid  = 1'b1;
    acc = ts;
    tick();
    trigger = 1'b0;
    repeat (24) tick();
    check("ovf_busy", 64'(busy), 64'd0);
    check("ovf_valid", 64'(dout_valid), 64'd1);
    check("ovf_head", 64'(dout), 64'({2'b01, WIDTH'(acc)}));
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("full_drop_busy", 64'(busy), 64'd0);
    dout_ready = 1'b1;
    n = 0;
    while (got.size() < 16 && n < 100) begin
      tick();
      n++;
    end
    eq.delete();
    eq.push_back({2'b01, WIDTH'(acc)});
    for (int k = 1; k <= 14; k++) eq.push_back({2'b00, din_val(acc + k)});
    eq.push_back(ftr_word(14, 1, 0));
    compare_frame("t3_ovf", eq, 16);
    $display("frame t3_ovf: ts=%0d len=20 words=%0d", acc, got.size());

    // Zero-length window: header and footer on consecutive edges.
    got.delete();
    din_valid  = 1'b0;
    trigger    = 1'b1;
    window_len = 16'd0;
    acc = ts;
    tick();
    trigger = 1'b0;
    check("len0_busy1", 64'(busy), 64'd1);
    tick();
    check("len0_busy0", 64'(busy), 64'd0);
    n = 0;
    while (got.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    eq.delete();
    eq.push_back({2'b01, WIDTH'(acc)});
    eq.push_back(ftr_word(0, 0, D1));
    compare_frame("t4_len0", eq, 2);
    $display("frame t4_len0: ts=%0d len=0 words=%0d", acc, got.size());

    // Reset in the middle of a capture, then a clean frame.
    got.delete();
    trigger    = 1'b1;
    window_len = 16'd8;
    din_valid  = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 64'(dout_valid), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_dout", 64'(dout), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    got.delete();
    tick();
    v5 = '{"t5_after_rst", 0, 3, 0, -1, 0, 5, 3, 0, 0};
    run_frame(v5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
